// File: rtl/dff_pipe_chain.sv
// dff_pipe_chain: a DEPTH-stage, WIDTH-bit register delay line with a valid
// bit per stage, clock enable (stall), synchronous clear, programmable reset
// value and a registered count of valid stages.
//
// Optional build macro: DFF_PIPE_TAP_EN
//   When defined, every stage's data and valid bit are exported on the
//   taps / tap_valid ports. When undefined, stage contents stay internal.
//
// Valid semantics: d_valid qualifies d on each enabled edge; the data word
// moves through the chain whether or not it is valid, and q_valid qualifies
// q in the same way. There is no ready/backpressure: en=0 stalls the whole
// chain, and the oldest stage is dropped on every enabled edge.
module dff_pipe_chain #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   vcount
`ifdef DFF_PIPE_TAP_EN
  ,
  output logic [WIDTH*DEPTH-1:0]       taps,
  output logic [DEPTH-1:0]             tap_valid
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  // Stage 0 is the input end, stage DEPTH-1 drives q.
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [CW-1:0]    vcount_r;
  logic [CW-1:0]    vcount_next;

  // Count update: one word enters and the last stage leaves on every enabled
  // edge. Modular arithmetic keeps the intermediate overflow harmless.
  always_comb begin
    vcount_next = vcount_r + CW'(d_valid) - CW'(valid_r[DEPTH-1]);
  end

  // Stage registers: async reset > sync clear > enabled shift > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RESET_VAL;
      end
      valid_r  <= '0;
      vcount_r <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
      end
      valid_r  <= '0;
      vcount_r <= '0;
    end else if (en) begin
      data_r[0]  <= d;
      valid_r[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i]  <= data_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
      vcount_r <= vcount_next;
    end
  end

  // Outputs come straight from the last stage and the count register.
  always_comb begin
    q       = data_r[DEPTH-1];
    q_valid = valid_r[DEPTH-1];
    vcount  = vcount_r;
  end

`ifdef DFF_PIPE_TAP_EN
  // Flatten every stage onto the tap ports, stage i at [i*WIDTH +: WIDTH].
  always_comb begin
    taps = '0;
    for (int i = 0; i < DEPTH; i++) begin
      taps[i*WIDTH +: WIDTH] = data_r[i];
    end
    tap_valid = valid_r;
  end
`else
  // Stage contents are internal only in this build.
`endif

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Bench for dff_pipe_chain (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
// Reference model: a queue of {data, valid} words, front = stage 0.
module tb_dff_pipe_chain;

  localparam int             W  = 8;
  localparam int             D  = 3;
  localparam logic [W-1:0]   RV = 8'hA5;
  localparam int             CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr;
  logic [W-1:0]  d;
  logic          d_valid;
  logic [W-1:0]  q;
  logic          q_valid;
  logic [CW-1:0] vcount;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]   pipe_m[$];
  logic [W-1:0] exp_q[$];

  dff_pipe_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .vcount  (vcount)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_fill(input logic [W-1:0] val);
    pipe_m.delete();
    for (int i = 0; i < D; i++) pipe_m.push_back({val, 1'b0});
  endfunction

  function automatic logic [W-1:0] m_q();
    return pipe_m[D-1][W:1];
  endfunction

  function automatic logic m_qv();
    return pipe_m[D-1][0];
  endfunction

  function automatic logic [CW-1:0] m_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(pipe_m[i][0]);
    return CW'(c);
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, model the posedge, return 1 time unit after.
  task automatic tick(input logic t_en, input logic t_clr,
                      input logic [W-1:0] t_d, input logic t_dv);
    @(negedge clk);
    en = t_en; clr = t_clr; d = t_d; d_valid = t_dv;
    @(posedge clk);
    if (rst) begin
      if (t_clr) model_fill('0);
      else if (t_en) begin
        pipe_m.push_front({t_d, t_dv});
        void'(pipe_m.pop_back());
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; clr = 1'b0;
    model_fill(RV);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Assert reset between edges (called right after tick returns).
  task automatic mid_reset();
    #1;
    rst = 1'b0;
    model_fill(RV);
    exp_q.delete();
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; clr = 1'b1; d = 8'h3C; d_valid = 1'b1;
    model_fill(RV);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (q !== RV || q_valid !== 1'b0 || vcount !== '0) begin
        n_errors++;
        $display("FAIL reset_hold: q=%h qv=%b vc=%0d expected q=%h qv=0 vc=0", q, q_valid, vcount, RV);
      end
    end
    release_rst();
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 8'h5A, 1'b1);
    n_checks++;
    if (q !== 8'h5A || q_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_prefill: q=%h qv=%b expected q=5a qv=1", q, q_valid);
    end
    mid_reset();
    n_checks++;
    if (q !== RV || q_valid !== 1'b0 || vcount !== '0) begin
      n_errors++;
      $display("FAIL reset_async: q=%h qv=%b vc=%0d expected q=%h qv=0 vc=0", q, q_valid, vcount, RV);
    end
    release_rst();
  endtask

  task automatic test_fill();
    logic [W-1:0]  exp_d  [6] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
    logic          exp_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [CW-1:0] exp_c  [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, W'(k + 1), 1'b1);
      n_checks++;
      if (q !== exp_d[k] || q_valid !== exp_v[k] || vcount !== exp_c[k]) begin
        n_errors++;
        $display("FAIL fill[%0d]: q=%h qv=%b vc=%0d expected q=%h qv=%b vc=%0d",
                 k, q, q_valid, vcount, exp_d[k], exp_v[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    tick(1'b1, 1'b0, 8'h11, 1'b1);
    tick(1'b1, 1'b0, 8'h22, 1'b1);
    tick(1'b1, 1'b0, 8'h33, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, W'($urandom), 1'($urandom_range(0, 1)));
      n_checks++;
      if (q !== 8'h11 || q_valid !== 1'b1 || vcount !== 2'd3) begin
        n_errors++;
        $display("FAIL stall[%0d]: q=%h qv=%b vc=%0d expected q=11 qv=1 vc=3", k, q, q_valid, vcount);
      end
    end
    tick(1'b1, 1'b0, 8'h44, 1'b1);
    n_checks++;
    if (q !== 8'h22 || vcount !== 2'd3) begin
      n_errors++;
      $display("FAIL stall_resume: q=%h vc=%0d expected q=22 vc=3", q, vcount);
    end
  endtask

  task automatic test_valid_gap();
    logic [W-1:0]  in_d  [5] = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
    logic          in_v  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0]  exp_d [5] = '{8'hA5, 8'hA5, 8'hAA, 8'hBB, 8'hCC};
    logic          exp_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [CW-1:0] exp_c [5] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b0, in_d[k], in_v[k]);
      n_checks++;
      if (q !== exp_d[k] || q_valid !== exp_v[k] || vcount !== exp_c[k]) begin
        n_errors++;
        $display("FAIL valid_gap[%0d]: q=%h qv=%b vc=%0d expected q=%h qv=%b vc=%0d",
                 k, q, q_valid, vcount, exp_d[k], exp_v[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, W'($urandom_range(1, 255)), 1'b1);
    n_checks++;
    if (vcount !== 2'd3) begin
      n_errors++;
      $display("FAIL clear_prefill: vc=%0d expected 3", vcount);
    end
    tick(1'b0, 1'b1, W'($urandom), 1'b1);
    n_checks++;
    if (q !== 8'h00 || q_valid !== 1'b0 || vcount !== '0) begin
      n_errors++;
      $display("FAIL clear: q=%h qv=%b vc=%0d expected q=00 qv=0 vc=0", q, q_valid, vcount);
    end
    tick(1'b1, 1'b0, 8'hFF, 1'b0);
    n_checks++;
    if (q !== 8'h00 || q_valid !== 1'b0 || vcount !== '0) begin
      n_errors++;
      $display("FAIL clear_after: q=%h qv=%b vc=%0d expected q=00 qv=0 vc=0", q, q_valid, vcount);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, W'($urandom), 1'b1);
    tick(1'b1, 1'b0, 8'h99, 1'b1);
    mid_reset();
    n_checks++;
    if (q !== RV || q_valid !== 1'b0 || vcount !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: q=%h qv=%b vc=%0d expected q=%h qv=0 vc=0", q, q_valid, vcount, RV);
    end
    @(posedge clk); #1;
    n_checks++;
    if (q !== RV || vcount !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_edge: q=%h vc=%0d expected q=%h vc=0", q, vcount, RV);
    end
    release_rst();
    tick(1'b1, 1'b0, 8'h7E, 1'b1);
    tick(1'b1, 1'b0, W'($urandom), 1'b0);
    n_checks++;
    if (q !== RV || q_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_early: q=%h qv=%b expected q=%h qv=0", q, q_valid, RV);
    end
    tick(1'b1, 1'b0, W'($urandom), 1'b0);
    n_checks++;
    if (q !== 8'h7E || q_valid !== 1'b1 || vcount !== 2'd1) begin
      n_errors++;
      $display("FAIL reset_mid_first: q=%h qv=%b vc=%0d expected q=7e qv=1 vc=1", q, q_valid, vcount);
    end
  endtask

  task automatic test_random();
    logic         t_en, t_clr, t_dv;
    logic [W-1:0] t_d;
    logic [W-1:0] e;
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        mid_reset();
        release_rst();
      end else begin
        t_en  = ($urandom_range(0, 3) != 0);
        t_clr = ($urandom_range(0, 29) == 0);
        t_dv  = 1'($urandom_range(0, 1));
        t_d   = W'($urandom);
        tick(t_en, t_clr, t_d, t_dv);
        // scoreboard: valid words must leave in entry order
        if (t_clr) exp_q.delete();
        else if (t_en) begin
          if (t_dv) exp_q.push_back(t_d);
          if (q_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_errors++;
              $display("FAIL rand_sb_empty[%0d]: q=%h delivered with no word expected", k, q);
            end else begin
              e = exp_q.pop_front();
              if (q !== e) begin
                n_errors++;
                $display("FAIL rand_sb[%0d]: q=%h expected %h", k, q, e);
              end
            end
          end
        end
      end
      n_checks++;
      if (q !== m_q() || q_valid !== m_qv() || vcount !== m_count()) begin
        n_errors++;
        $display("FAIL rand_model[%0d]: q=%h qv=%b vc=%0d expected q=%h qv=%b vc=%0d",
                 k, q, q_valid, vcount, m_q(), m_qv(), m_count());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; d = '0; d_valid = 1'b0;
    test_reset();
    test_fill();
    test_stall();
    test_valid_gap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
